// File: rtl/iterative_alu_if.sv
// rtl/iterative_alu_if.sv - operand/result handshake bundle for iterative_alu
interface iterative_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_in_1;
   logic [WIDTH-1:0] alu_in_2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             alu_illegal;

   modport master (
      output in_valid, alu_op, alu_in_1, alu_in_2, out_ready,
      input  in_ready, out_valid, alu_result, alu_zero, alu_illegal
   );

   modport slave (
      input  in_valid, alu_op, alu_in_1, alu_in_2, out_ready,
      output in_ready, out_valid, alu_result, alu_zero, alu_illegal
   );
endinterface

// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - single-cycle logic/arith ops plus 1-bit-per-cycle serial shifter
module iterative_alu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input logic            clk,
   input logic            reset,
   iterative_alu_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b1000;
   localparam logic [3:0] OP_SLL = 4'b1010;
   localparam logic [3:0] OP_SRL = 4'b1011;

   state_t             state;
   state_t             state_next;
   logic               accept;
   logic               legal;
   logic               is_shift;
   logic               shift_left;
   logic [SHAMT_W-1:0] shamt;
   logic [SHAMT_W-1:0] count;
   logic [WIDTH-1:0]   quick_result;
   logic [WIDTH-1:0]   work;
   logic [WIDTH-1:0]   shifted;
   logic [WIDTH-1:0]   result_q;
   logic               zero_q;
   logic               illegal_q;

   assign accept = bus.in_valid && (state == IDLE);
   assign shamt  = bus.alu_in_2[SHAMT_W-1:0];

   // A zero-distance shift finishes like a one-cycle op, returning operand A.
   always_comb begin
      quick_result = '0;
      legal        = 1'b1;
      is_shift     = 1'b0;
      case (bus.alu_op)
         OP_ADD:  quick_result = bus.alu_in_1 + bus.alu_in_2;
         OP_SUB:  quick_result = bus.alu_in_1 + ~bus.alu_in_2 + WIDTH'(1);
         OP_AND:  quick_result = bus.alu_in_1 & bus.alu_in_2;
         OP_OR:   quick_result = bus.alu_in_1 | bus.alu_in_2;
         OP_XOR:  quick_result = bus.alu_in_1 ^ bus.alu_in_2;
         OP_SLL, OP_SRL: begin
            is_shift     = 1'b1;
            quick_result = bus.alu_in_1;
         end
         default: legal = 1'b0;
      endcase
   end

   assign shifted = shift_left ? (work << 1) : (work >> 1);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (accept) state_next = (is_shift && shamt != '0) ? SHIFT : DONE;
         SHIFT: if (count == SHAMT_W'(1)) state_next = DONE;
         DONE:  if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q   <= '0;
         zero_q     <= 1'b0;
         illegal_q  <= 1'b0;
         count      <= '0;
         work       <= '0;
         shift_left <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_shift && shamt != '0) begin
                     work       <= bus.alu_in_1;
                     count      <= shamt;
                     shift_left <= (bus.alu_op == OP_SLL);
                  end else begin
                     result_q  <= quick_result;
                     zero_q    <= (quick_result == '0);
                     illegal_q <= !legal;
                  end
               end
            end
            SHIFT: begin
               work  <= shifted;
               count <= count - SHAMT_W'(1);
               if (count == SHAMT_W'(1)) begin
                  result_q  <= shifted;
                  zero_q    <= (shifted == '0);
                  illegal_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready    = (state == IDLE);
   assign bus.out_valid   = (state == DONE);
   assign bus.alu_result  = result_q;
   assign bus.alu_zero    = zero_q;
   assign bus.alu_illegal = illegal_q;
endmodule

// File: tb/tb_iterative_alu.sv
// tb/tb_iterative_alu.sv - scoreboard bench for iterative_alu with random and directed stimulus
module tb_iterative_alu;
   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ill;
      int          lat;
      int          c;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   prev_ov = 1'b0;
   bit   done = 1'b0;
   exp_t q[$];

   iterative_alu_if #(.WIDTH(32)) bus ();

   iterative_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
      end
   endfunction

   function automatic exp_t mk(logic [31:0] res, logic zero, logic ill, int lat);
      exp_t e;
      e.res = res; e.zero = zero; e.ill = ill; e.lat = lat; e.c = 0;
      return e;
   endfunction

   // Reference: plain arithmetic on the opcode; latency 1, or shamt+1 for shifts.
   function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      logic [31:0] r;
      int          s;
      logic        ill;
      int          lat;
      s   = int'(b % 32);
      ill = 1'b0;
      lat = 1;
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd4:  r = a & b;
         4'd5:  r = a | b;
         4'd8:  r = a ^ b;
         4'd10: begin r = a << s; lat = s + 1; end
         4'd11: begin r = a >> s; lat = s + 1; end
         default: begin r = 0; ill = 1'b1; end
      endcase
      return mk(r, r == 0, ill, lat);
   endfunction

   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
      exp_t ee;
      ee = e;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_op   = op;
      bus.alu_in_1 = a;
      bus.alu_in_2 = b;
      for (int i = 0; i < 200; i++) begin
         if (bus.in_ready) begin
            ee.c = cyc;
            q.push_back(ee);
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.alu_op   = 4'($urandom);
            bus.alu_in_1 = $urandom;
            bus.alu_in_2 = $urandom;
            return;
         end
         @(negedge clk);
      end
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept op=%h", op);
      bus.in_valid = 1'b0;
   endtask

   // Monitor runs just after each rising edge; out_ready still holds the value that edge saw.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (reset) begin
         chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
         chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
         chk("reset_result", bus.alu_result, 32'd0);
         chk("reset_zero", 32'(bus.alu_zero), 32'd0);
         chk("reset_illegal", 32'(bus.alu_illegal), 32'd0);
         q.delete();
         prev_ov = 1'b0;
      end else begin
         if (prev_ov && bus.out_ready && q.size() > 0) void'(q.pop_front());
         chk("in_ready", 32'(bus.in_ready), 32'(q.size() == 0));
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
               chk("result", bus.alu_result, q[0].res);
               chk("zero", 32'(bus.alu_zero), 32'(q[0].zero));
               chk("illegal", 32'(bus.alu_illegal), 32'(q[0].ill));
               if (!prev_ov) chk("latency", 32'(cyc - q[0].c), 32'(q[0].lat));
            end
         end
         prev_ov = bus.out_valid;
      end
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      bit          seen_reset_hold;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.alu_op    = 4'd0;
      bus.alu_in_1  = 32'd0;
      bus.alu_in_2  = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      send(4'b0000, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 1'b1, 1'b0, 1));
      send(4'b0001, 32'd5, 32'd7, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1));
      send(4'b1010, 32'h1, 32'h1F, mk(32'h8000_0000, 1'b0, 1'b0, 32));
      send(4'b1011, 32'h8000_0000, 32'hFFFF_FFE4, mk(32'h0800_0000, 1'b0, 1'b0, 5));
      send(4'b1011, 32'h1234_5678, 32'h20, mk(32'h1234_5678, 1'b0, 1'b0, 1));
      send(4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F, mk(32'h0F00_0F00, 1'b0, 1'b0, 1));
      send(4'b0101, 32'hA000_0000, 32'h0000_0005, mk(32'hA000_0005, 1'b0, 1'b0, 1));

      @(negedge clk);
      bus.out_ready = 1'b0;
      fork
         begin
            send(4'b1000, 32'h0000_F0F0, 32'h0000_FFFF, mk(32'h0000_0F0F, 1'b0, 1'b0, 1));
            send(4'b0000, 32'd1, 32'd2, mk(32'd3, 1'b0, 1'b0, 1));
         end
         begin
            repeat (5) @(negedge clk);
            bus.out_ready = 1'b1;
         end
      join

      send(4'b0111, 32'h1234, 32'h5678, mk(32'h0, 1'b1, 1'b1, 1));

      // An sll of 20 abandoned by reset must never emit a result.
      send(4'b1010, 32'h1, 32'd20, mk(32'h0010_0000, 1'b0, 1'b0, 21));
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      seen_reset_hold = 1'b1;

      fork
         begin
            for (int i = 0; i < 60; i++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               case ($urandom_range(0, 8))
                  0: op = 4'd0;  1: op = 4'd1;  2: op = 4'd4;
                  3: op = 4'd5;  4: op = 4'd8;  5: op = 4'd10;
                  6: op = 4'd11; default: op = 4'($urandom);
               endcase
               a = $urandom;
               b = ($urandom_range(0, 7) == 0) ? a : $urandom;
               send(op, a, b, model(op, a, b));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      bus.out_ready = 1'b1;

      for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("drain_empty", 32'(q.size()), 32'd0);
      chk("final_in_ready", 32'(bus.in_ready && seen_reset_hold), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
